shift_search_ctrl: RTL and testbench

Sequencer that drives a shiftcomp stage and consumes its `limit` output. On `start` it loads a seed into the shifter and holds a target on the comparator. It then counts shift cycles until `limit` asserts or a step budget runs out, and reports found/not-found and the step count. It sits directly around shiftcomp in the parent: its `load`/`init`/`test` outputs feed shiftcomp, and shiftcomp's `limit` returns to it.

---
 rtl/shift_search_ctrl_pkg.sv | 16 +
 rtl/shift_search_ctrl_if.sv | 29 ++
 rtl/shift_search_ctrl.sv | 102 ++++++++++
 tb/tb_shift_search_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shift_search_ctrl_pkg.sv
// Shared types and defaults for the shift/compare search sequencer.
// The data width must stay in step with the shiftcomp stage it drives.
package shift_search_pkg;

    localparam int DATA_W        = 8;
    localparam int MAX_STEPS_DEF = 16;
    localparam int STEP_W_DEF    = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEARCH,
        DONE
    } state_t;

endpackage

// File: rtl/shift_search_ctrl_if.sv
// Request/result bundle between the parent (master) and the search sequencer (slave).
// The same bundle carries the shiftcomp-facing load/init/test/limit signals.
interface shift_search_ctrl_if #(
    parameter int STEP_W = shift_search_pkg::STEP_W_DEF
);

    logic                               start;
    logic [shift_search_pkg::DATA_W-1:0] seed;
    logic [shift_search_pkg::DATA_W-1:0] target;
    logic                               limit;
    logic                               load;
    logic [shift_search_pkg::DATA_W-1:0] init;
    logic [shift_search_pkg::DATA_W-1:0] test;
    logic                               busy;
    logic                               done;
    logic                               found;
    logic [STEP_W-1:0]                  steps;

    modport master (
        output start, seed, target, limit,
        input  load, init, test, busy, done, found, steps
    );

    modport slave (
        input  start, seed, target, limit,
        output load, init, test, busy, done, found, steps
    );

endinterface

// File: rtl/shift_search_ctrl.sv
// Loads a seed into shiftcomp, then counts shift cycles until limit fires
// or the step budget is spent; reports found/steps with a one-cycle done.
//
// state  | meaning
// IDLE   | waiting for start; seed/target captured on acceptance
// LOAD   | load strobe high, shiftcomp takes init this edge
// SEARCH | shifter advances each edge; counter k = shifts since load
// DONE   | done pulse, result registers valid
module shift_search_ctrl
    import shift_search_pkg::*;
#(
    parameter int MAX_STEPS = MAX_STEPS_DEF,
    parameter int STEP_W    = STEP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    shift_search_ctrl_if.slave bus
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   init_q, init_d;
    logic [DATA_W-1:0]   test_q, test_d;
    logic                found_q, found_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic                load_q;
    logic                busy_q;
    logic                done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        test_d  = test_q;
        found_d = found_q;
        steps_d = steps_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    init_d  = bus.seed;
                    test_d  = bus.target;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    steps_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = SEARCH;
            SEARCH: begin
                if (bus.limit) begin
                    found_d = 1'b1;
                    steps_d = cnt_q;
                    state_d = DONE;
                end else if (cnt_q == LAST_STEP) begin
                    found_d = 1'b0;
                    steps_d = LAST_STEP;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            init_q  <= '0;
            test_q  <= '0;
            found_q <= 1'b0;
            steps_q <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            test_q  <= test_d;
            found_q <= found_d;
            steps_q <= steps_d;
            load_q  <= (state_d == LOAD);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.load  = load_q;
    assign bus.init  = init_q;
    assign bus.test  = test_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.found = found_q;
    assign bus.steps = steps_q;

endmodule

// File: tb/tb_shift_search_ctrl.sv
// Bench for shift_search_ctrl: directed vector table, random runs against a
// rotating-shifter model, and hand sequences for reset and ignored starts.
module tb_shift_search_ctrl;

    localparam int MAXS = 16;
    localparam int SW   = 5;
    localparam int NEVER = 99;

    typedef struct {
        logic [7:0] seed;
        logic [7:0] target;
        int         mode;      // 0: limit only at counter k, 1: limit only in IDLE/LOAD, 2: shifter model
        int         k;
        int         inj;       // cycle to pulse a stray start, or 0 for none
        logic       exp_found;
        int         exp_steps;
        int         exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    shift_search_ctrl_if #(.STEP_W(SW)) bus ();

    shift_search_ctrl #(.MAX_STEPS(MAXS), .STEP_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Reference: the first shift count (within budget) whose shifter value equals target.
    function automatic vec_t model_vec(input logic [7:0] s, input logic [7:0] t);
        vec_t v;
        v.seed = s; v.target = t; v.mode = 2; v.k = NEVER; v.inj = 0;
        v.exp_found = 1'b0; v.exp_steps = MAXS - 1; v.exp_done = MAXS + 2;
        for (int k = MAXS - 1; k >= 0; k--) begin
            if (rotl(s, k) == t) begin
                v.exp_found = 1'b1; v.exp_steps = k; v.exp_done = 3 + k;
            end
        end
        return v;
    endfunction

    function automatic logic lim(input vec_t v, input int c);
        case (v.mode)
            0: return (c == 2 + v.k);
            1: return (c < 2);
            default: return (c < 2) ? logic'($urandom_range(0, 1)) : (rotl(v.seed, c - 2) == v.target);
        endcase
    endfunction

    task automatic run(input vec_t v, input string tag);
        int c;
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.seed   = v.seed;
        bus.target = v.target;
        bus.limit  = lim(v, 0);
        @(posedge clk); #1;
        c = 1;
        bus.start  = 1'b0;
        bus.seed   = ~v.seed;
        bus.target = ~v.target;
        while (c <= v.exp_done + 1) begin
            check({tag, " load"}, 32'(bus.load), 32'(c == 1));
            check({tag, " busy"}, 32'(bus.busy), 32'(c <= v.exp_done));
            check({tag, " done"}, 32'(bus.done), 32'(c == v.exp_done));
            if (c == 1) begin
                check({tag, " found cleared"}, 32'(bus.found), 32'd0);
                check({tag, " steps cleared"}, 32'(bus.steps), 32'd0);
            end
            if (c == 1 || c == v.exp_done) begin
                check({tag, " init"}, 32'(bus.init), 32'(v.seed));
                check({tag, " test"}, 32'(bus.test), 32'(v.target));
            end
            if (c == v.exp_done) begin
                check({tag, " found"}, 32'(bus.found), 32'(v.exp_found));
                check({tag, " steps"}, 32'(bus.steps), 32'(v.exp_steps));
            end
            bus.limit = lim(v, c);
            bus.start = (v.inj != 0 && c == v.inj);
            if (bus.start) begin
                bus.seed   = 8'hC3;
                bus.target = 8'h3C;
            end
            @(posedge clk); #1;
            c++;
        end
        bus.start = 1'b0;
        bus.limit = 1'b0;
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        bus.start = 1'b0; bus.seed = '0; bus.target = '0; bus.limit = 1'b0;
        #2 rst = 1'b0;
        #2;
        check("reset load",  32'(bus.load),  32'd0);
        check("reset init",  32'(bus.init),  32'd0);
        check("reset test",  32'(bus.test),  32'd0);
        check("reset busy",  32'(bus.busy),  32'd0);
        check("reset done",  32'(bus.done),  32'd0);
        check("reset found", 32'(bus.found), 32'd0);
        check("reset steps", 32'(bus.steps), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        //            seed   target mode k      inj found steps done
        tbl[0] = '{8'h81, 8'h81, 0, 0,     0, 1'b1, 0,  3};
        tbl[1] = '{8'h3C, 8'hA5, 0, 5,     0, 1'b1, 5,  8};
        tbl[2] = '{8'h12, 8'h34, 0, NEVER, 0, 1'b0, 15, 18};
        tbl[3] = '{8'h55, 8'hAA, 0, 15,    0, 1'b1, 15, 18};
        tbl[4] = '{8'h0F, 8'hF0, 1, NEVER, 0, 1'b0, 15, 18};
        tbl[5] = '{8'h77, 8'h11, 0, 4,     3, 1'b1, 4,  7};
        tbl[6] = '{8'h01, 8'h08, 2, NEVER, 0, 1'b1, 3,  6};
        for (int i = 0; i < 7; i++) run(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            logic [7:0] s, t;
            s = 8'($urandom);
            t = ($urandom_range(0, 3) == 0) ? 8'($urandom) : rotl(s, $urandom_range(0, 9));
            rv = model_vec(s, t);
            run(rv, $sformatf("rnd%0d", i));
        end

        // Reset while SEARCH holds counter 3 (cycle 5); nothing may survive it.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.seed = 8'h9E; bus.target = 8'h00; bus.limit = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst load",  32'(bus.load),  32'd0);
        check("midrst init",  32'(bus.init),  32'd0);
        check("midrst test",  32'(bus.test),  32'd0);
        check("midrst busy",  32'(bus.busy),  32'd0);
        check("midrst done",  32'(bus.done),  32'd0);
        check("midrst found", 32'(bus.found), 32'd0);
        check("midrst steps", 32'(bus.steps), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst no done", 32'(bus.done), 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("post-rst no done", 32'(bus.done), 32'd0);
        end
        run('{8'h44, 8'h22, 0, 2, 0, 1'b1, 2, 5}, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
